// File: rtl/arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Grant state encoding and default bus widths.
package arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int SEL_WIDTH      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } grant_e;

endpackage

// File: rtl/arb_grant_fsm.sv
// Grant state machine for the two-master arbiter.
// Build with ARB_ROUND_ROBIN_EN for alternating tie-breaks.
module arb_grant_fsm
  import arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req0,
  input  logic   req1,
  output grant_e grant
);

  grant_e nxt;
  grant_e arb;
  logic   m0_first;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1;

  assign m0_first = last_m1;

  // remember which master was granted most recently
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_m1 <= 1'b1;
    end else if (nxt == GNT_M0) begin
      last_m1 <= 1'b0;
    end else if (nxt == GNT_M1) begin
      last_m1 <= 1'b1;
    end
  end
`else
  assign m0_first = 1'b1;
`endif

  // pick a new owner from the current requests
  always_comb begin
    arb = IDLE;
    if (req0 && req1) begin
      arb = m0_first ? GNT_M0 : GNT_M1;
    end else if (req0) begin
      arb = GNT_M0;
    end else if (req1) begin
      arb = GNT_M1;
    end
  end

  // owner keeps the bus until it drops cyc
  always_comb begin
    nxt = IDLE;
    unique case (grant)
      IDLE:    nxt = arb;
      GNT_M0:  nxt = req0 ? GNT_M0 : arb;
      GNT_M1:  nxt = req1 ? GNT_M1 : arb;
      default: nxt = IDLE;
    endcase
  end

  // grant state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant <= IDLE;
    end else begin
      grant <= nxt;
    end
  end

endmodule

// File: rtl/arbiter_2_masters.sv
// Two-master Wishbone arbiter: one slave port shared by m0/m1.
// ARB_ROUND_ROBIN_EN selects alternating tie-breaks (default: m0 wins).
module arbiter_2_masters
  import arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_m0_we,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_cyc,
  input  logic [SEL_WIDTH-1:0]  i_m0_sel,
  input  logic [DATA_WIDTH-1:0] i_m0_dat,
  input  logic [ADDR_WIDTH-1:0] i_m0_adr,
  output logic [DATA_WIDTH-1:0] o_m0_dat,
  output logic                  o_m0_ack,
  output logic                  o_m0_int,

  input  logic                  i_m1_we,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_cyc,
  input  logic [SEL_WIDTH-1:0]  i_m1_sel,
  input  logic [DATA_WIDTH-1:0] i_m1_dat,
  input  logic [ADDR_WIDTH-1:0] i_m1_adr,
  output logic [DATA_WIDTH-1:0] o_m1_dat,
  output logic                  o_m1_ack,
  output logic                  o_m1_int,

  output logic                  o_s_we,
  output logic                  o_s_stb,
  output logic                  o_s_cyc,
  output logic [SEL_WIDTH-1:0]  o_s_sel,
  output logic [DATA_WIDTH-1:0] o_s_dat,
  output logic [ADDR_WIDTH-1:0] o_s_adr,
  input  logic [DATA_WIDTH-1:0] i_s_dat,
  input  logic                  i_s_ack,
  input  logic                  i_s_int
);

  grant_e grant;

  arb_grant_fsm u_fsm (
    .clk   (clk),
    .rst   (rst),
    .req0  (i_m0_cyc),
    .req1  (i_m1_cyc),
    .grant (grant)
  );

  assign o_m0_int = i_s_int;
  assign o_m1_int = i_s_int;

  // route the owner's request to the slave and the response back
  always_comb begin
    o_s_we   = 1'b0;
    o_s_stb  = 1'b0;
    o_s_cyc  = 1'b0;
    o_s_sel  = '0;
    o_s_dat  = '0;
    o_s_adr  = '0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    unique case (grant)
      GNT_M0: begin
        o_s_we   = i_m0_we;
        o_s_stb  = i_m0_stb;
        o_s_cyc  = i_m0_cyc;
        o_s_sel  = i_m0_sel;
        o_s_dat  = i_m0_dat;
        o_s_adr  = i_m0_adr;
        o_m0_dat = i_s_dat;
        o_m0_ack = i_s_ack;
      end
      GNT_M1: begin
        o_s_we   = i_m1_we;
        o_s_stb  = i_m1_stb;
        o_s_cyc  = i_m1_cyc;
        o_s_sel  = i_m1_sel;
        o_s_dat  = i_m1_dat;
        o_s_adr  = i_m1_adr;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arbiter_2_masters.sv
// Scoreboard bench for arbiter_2_masters.
// Directed vectors; owner per cycle is written by hand.
module tb_arbiter_2_masters;
  import arbiter_pkg::*;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } mreq_t;

  typedef struct {
    grant_e      own;
    mreq_t       m0;
    mreq_t       m1;
    logic [31:0] sdat;
    logic        sack;
    logic        sint;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [3:0] m0_sel, m1_sel, s_sel;
  logic [31:0] m0_dat, m0_adr, m1_dat, m1_adr;
  logic [31:0] m0_odat, m1_odat, s_dat, s_adr, s_idat;
  logic m0_ack, m0_int, m1_ack, m1_int;
  logic s_we, s_stb, s_cyc, s_ack, s_int;

  exp_t q[$];
  exp_t e;
  mreq_t o;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arbiter_2_masters #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_m0_we(m0_we), .i_m0_stb(m0_stb), .i_m0_cyc(m0_cyc),
    .i_m0_sel(m0_sel), .i_m0_dat(m0_dat), .i_m0_adr(m0_adr),
    .o_m0_dat(m0_odat), .o_m0_ack(m0_ack), .o_m0_int(m0_int),
    .i_m1_we(m1_we), .i_m1_stb(m1_stb), .i_m1_cyc(m1_cyc),
    .i_m1_sel(m1_sel), .i_m1_dat(m1_dat), .i_m1_adr(m1_adr),
    .o_m1_dat(m1_odat), .o_m1_ack(m1_ack), .o_m1_int(m1_int),
    .o_s_we(s_we), .o_s_stb(s_stb), .o_s_cyc(s_cyc),
    .o_s_sel(s_sel), .o_s_dat(s_dat), .o_s_adr(s_adr),
    .i_s_dat(s_idat), .i_s_ack(s_ack), .i_s_int(s_int)
  );

  task automatic check(string tag, string f,
                       logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h want %0h", tag, f, act, exp);
    end
  endtask

  // monitor: compare one expected snapshot per cycle
  always @(posedge clk) begin
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      o = '0;
      if (e.own == GNT_M0) o = e.m0;
      if (e.own == GNT_M1) o = e.m1;
      check(e.tag, "s_cyc", 32'(s_cyc), 32'(o.cyc));
      check(e.tag, "s_stb", 32'(s_stb), 32'(o.cyc));
      check(e.tag, "s_we", 32'(s_we), 32'(o.we));
      check(e.tag, "s_sel", 32'(s_sel), 32'(o.sel));
      check(e.tag, "s_adr", s_adr, o.adr);
      check(e.tag, "s_dat", s_dat, o.dat);
      check(e.tag, "m0_ack", 32'(m0_ack),
            32'((e.own == GNT_M0) & e.sack));
      check(e.tag, "m1_ack", 32'(m1_ack),
            32'((e.own == GNT_M1) & e.sack));
      check(e.tag, "m0_dat", m0_odat,
            (e.own == GNT_M0) ? e.sdat : 32'h0);
      check(e.tag, "m1_dat", m1_odat,
            (e.own == GNT_M1) ? e.sdat : 32'h0);
      check(e.tag, "m0_int", 32'(m0_int), 32'(e.sint));
      check(e.tag, "m1_int", 32'(m1_int), 32'(e.sint));
    end
  end

  function automatic mreq_t mk(logic we, logic [31:0] adr,
                               logic [31:0] dat, logic [3:0] sel);
    mreq_t r;
    r.cyc = 1'b1;
    r.we  = we;
    r.sel = sel;
    r.adr = adr;
    r.dat = dat;
    return r;
  endfunction

  task automatic step(logic r, mreq_t a, mreq_t b,
                      logic [31:0] sd, logic sa, logic si,
                      grant_e own, string tag);
    exp_t x;
    @(negedge clk);
    rst    = r;
    m0_cyc = a.cyc; m0_stb = a.cyc; m0_we = a.we;
    m0_sel = a.sel; m0_adr = a.adr; m0_dat = a.dat;
    m1_cyc = b.cyc; m1_stb = b.cyc; m1_we = b.we;
    m1_sel = b.sel; m1_adr = b.adr; m1_dat = b.dat;
    s_idat = sd; s_ack = sa; s_int = si;
    x.own = own; x.m0 = a; x.m1 = b;
    x.sdat = sd; x.sack = sa; x.sint = si; x.tag = tag;
    q.push_back(x);
  endtask

  initial begin
    mreq_t nn, w0, r0, r1, w1;
    grant_e rr_own;
    int k;
    nn = '0;
    w0 = mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    r0 = mk(1'b0, 32'h20, 32'h0, 4'hF);
    r1 = mk(1'b0, 32'h4, 32'h0, 4'h3);
    w1 = mk(1'b1, 32'h8, 32'hCAFE0001, 4'h3);
    rst = 1'b0;
    {m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc} = '0;
    {m0_sel, m1_sel} = '0;
    {m0_dat, m0_adr, m1_dat, m1_adr, s_idat} = '0;
    {s_ack, s_int} = '0;

    step(0, nn, nn, 0, 0, 0, IDLE, "rst0");
    step(0, nn, nn, 0, 0, 0, IDLE, "rst1");
    step(0, w0, w1, 32'h55, 1, 0, IDLE, "rst_req");
    step(1, nn, nn, 32'h0, 0, 1, IDLE, "int_idle");

    step(1, w0, nn, 0, 0, 0, GNT_M0, "m0_wr");
    step(1, w0, nn, 32'h0, 1, 0, GNT_M0, "m0_ack");
    step(1, nn, nn, 0, 0, 0, IDLE, "m0_done");

    step(0, nn, nn, 0, 0, 0, IDLE, "rst_b");
    step(1, w0, w1, 0, 0, 0, GNT_M0, "tie");
    step(1, w0, w1, 32'h0, 1, 1, GNT_M0, "tie_ack");
    step(1, nn, w1, 0, 0, 0, GNT_M1, "handover");
    step(1, nn, w1, 32'h0, 1, 0, GNT_M1, "m1_wack");
    step(1, nn, nn, 0, 0, 0, IDLE, "m1_done");

    step(1, nn, r1, 0, 0, 0, GNT_M1, "m1_rd");
    step(1, r0, r1, 32'h12345678, 1, 0, GNT_M1, "m1_rdack");
    step(1, r0, r1, 32'h0, 0, 0, GNT_M1, "no_preempt");
    step(1, r0, nn, 32'h9, 1, 0, GNT_M0, "m0_after");
    step(1, nn, nn, 0, 0, 0, IDLE, "m0_done2");

    step(0, nn, nn, 0, 0, 0, IDLE, "rst_c");
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      rr_own = (i % 2 == 0) ? GNT_M0 : GNT_M1;
`else
      rr_own = GNT_M0;
`endif
      step(1, w0, w1, 32'hA0 + 32'(i), 1, 0, rr_own, "rr_gnt");
      step(1, nn, nn, 0, 0, 0, IDLE, "rr_idle");
    end

    step(1, r0, nn, 0, 0, 0, GNT_M0, "m0_xfer");
    step(0, r0, nn, 32'h77, 1, 0, IDLE, "rst_mid");
    step(1, r0, nn, 0, 0, 0, GNT_M0, "regrant");
    step(1, nn, nn, 0, 0, 0, IDLE, "end_idle");

    k = 0;
    while (q.size() != 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
